// File: rtl/cnt_scan_pkg.sv
// Shared types, glyph table and width helper for the counter/scan display blocks.
package cnt_scan_pkg;

  typedef logic [3:0] digit_t;

  // Segment glyphs {dp,g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [7:0] SEG_ROM [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  // Bits needed to hold 0..n-1; never returns less than 1 so counters stay legal
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: time-multiplexed 7-segment driver with registered digit select and segments.
// Leading-zero blanking is built in when CNT_UPDOWN_SCAN_BLANK_EN is defined.
module seg7_scan_drv
  import cnt_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits,
  output logic [5:0]            scan,
  output logic [7:0]            dout
);

  localparam int unsigned SW = clog2(SCAN_DIV);
  localparam int unsigned IW = clog2(DIGITS);

  logic [SW-1:0] div;
  logic [IW-1:0] idx;
  digit_t        cur_digit_c;
  logic [5:0]    sel_c;
  logic          blank_c;

  // Dwell counter and digit index; index wraps after the last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == SW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      div <= div + SW'(1);
    end
  end

  // Select the active digit value and its one-hot enable
  always_comb begin
    cur_digit_c = '0;
    sel_c       = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IW'(i)) begin
        cur_digit_c = digits[4*i +: 4];
        sel_c       = 6'(1) << i;
      end
    end
  end

`ifdef CNT_UPDOWN_SCAN_BLANK_EN
  // Blank a non-zero index when it and every higher digit are zero
  always_comb begin
    blank_c = 1'b0;
    for (int i = 1; i < int'(DIGITS); i++) begin
      if ((idx == IW'(i)) && ((digits >> (4*i)) == '0)) begin
        blank_c = 1'b1;
      end
    end
  end
`else
  assign blank_c = 1'b0;
`endif

  // Register select and segments together so the two never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      scan <= 6'b000001;
      dout <= SEG_ROM[0];
    end else begin
      scan <= sel_c;
      dout <= blank_c ? 8'h00 : SEG_ROM[cur_digit_c];
    end
  end

endmodule

// File: rtl/cnt_updown_scan.sv
// cnt_updown_scan: N-digit up/down counter stepped by an internal tick or a debounced
// button, driving a multiplexed 7-segment display.
// Define CNT_UPDOWN_SCAN_BLANK_EN for leading-zero blanking on the display.
module cnt_updown_scan
  import cnt_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned RADIX    = 16,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DB_DIV   = 10000,
  parameter int unsigned SCAN_DIV = 100
) (
  input  logic                  clk100khz,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  din,
  input  logic                  op,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_val,
  output logic [4*DIGITS-1:0]   cnt_val,
  output logic                  wrap,
  output logic                  at_zero,
  output logic [5:0]            scan,
  output logic [7:0]            dout
);

  localparam int unsigned DW   = 4 * DIGITS;
  localparam int unsigned TW   = clog2(TICK_DIV);
  localparam int unsigned BW   = clog2(DB_DIV);
  localparam digit_t      MAXD = 4'(RADIX - 1);

  logic [TW-1:0] tick_div;
  logic          tick_c;
  logic          din_meta;
  logic          din_sync;
  logic [BW-1:0] db_div;
  logic          db_sample_c;
  logic          db_last;
  logic          db_level;
  logic          press;
  logic          step_c;
  logic [DW-1:0] cnt_nxt_c;
  logic          wrap_nxt_c;
  logic          carry_c;
  digit_t        ld_dig_c;

  assign tick_c      = (tick_div == TW'(TICK_DIV - 1));
  assign db_sample_c = (db_div == BW'(DB_DIV - 1));
  assign step_c      = en ? press : tick_c;

  // Free-running count-tick prescaler
  always_ff @(posedge clk100khz) begin
    if (rst || tick_c) begin
      tick_div <= '0;
    end else begin
      tick_div <= tick_div + TW'(1);
    end
  end

  // Button synchroniser, slow sampler and two-sample debounce; press marks the debounced fall
  always_ff @(posedge clk100khz) begin
    if (rst) begin
      din_meta <= 1'b1;
      din_sync <= 1'b1;
      db_div   <= '0;
      db_last  <= 1'b1;
      db_level <= 1'b1;
      press    <= 1'b0;
    end else begin
      din_meta <= din;
      din_sync <= din_meta;
      db_div   <= db_sample_c ? '0 : db_div + BW'(1);
      press    <= 1'b0;
      if (db_sample_c) begin
        db_last <= din_sync;
        if (db_last == din_sync) begin
          db_level <= din_sync;
          press    <= db_level & ~din_sync;
        end
      end
    end
  end

  // Next count: load with per-digit clamp beats a step; up ripples a carry, down saturates at zero
  always_comb begin
    cnt_nxt_c  = cnt_val;
    wrap_nxt_c = 1'b0;
    carry_c    = 1'b1;
    ld_dig_c   = '0;
    if (ld) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        ld_dig_c = ld_val[4*i +: 4];
        cnt_nxt_c[4*i +: 4] = (ld_dig_c > MAXD) ? MAXD : ld_dig_c;
      end
    end else if (step_c) begin
      if (!op) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (carry_c) begin
            if (cnt_val[4*i +: 4] == MAXD) begin
              cnt_nxt_c[4*i +: 4] = '0;
            end else begin
              cnt_nxt_c[4*i +: 4] = cnt_val[4*i +: 4] + 4'd1;
              carry_c = 1'b0;
            end
          end
        end
        wrap_nxt_c = carry_c;
      end else if (cnt_val != '0) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (carry_c) begin
            if (cnt_val[4*i +: 4] == 4'd0) begin
              cnt_nxt_c[4*i +: 4] = MAXD;
            end else begin
              cnt_nxt_c[4*i +: 4] = cnt_val[4*i +: 4] - 4'd1;
              carry_c = 1'b0;
            end
          end
        end
      end
    end
  end

  // Count register with its wrap pulse and zero flag
  always_ff @(posedge clk100khz) begin
    if (rst) begin
      cnt_val <= '0;
      wrap    <= 1'b0;
      at_zero <= 1'b1;
    end else begin
      cnt_val <= cnt_nxt_c;
      wrap    <= wrap_nxt_c;
      at_zero <= (cnt_nxt_c == '0);
    end
  end

  seg7_scan_drv #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_drv (
    .clk    (clk100khz),
    .rst    (rst),
    .digits (cnt_val),
    .scan   (scan),
    .dout   (dout)
  );

endmodule

// File: tb/tb_cnt_updown_scan.sv
// Bench for cnt_updown_scan: a hex and a decimal instance share stimulus and are compared
// every cycle against an arithmetic reference model, plus directed checks.
module tb_cnt_updown_scan;

  localparam int ND   = 2;
  localparam int TDIV = 4;
  localparam int SDIV = 3;
  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic clk100khz;
  logic rst, en, din, op, ld;
  logic [7:0] ld_val;
  logic [1:0][7:0] cnt_o;
  logic [1:0]      wrap_o;
  logic [1:0]      at_zero_o;
  logic [1:0][5:0] scan_o;
  logic [1:0][7:0] dout_o;

  int n_tests = 0;
  int n_fail  = 0;
  int radix [2] = '{16, 10};
  int m_v [2];
  int m_tph, m_sph, m_idx;
  bit m_step;
  bit chk_cnt;
  int w_cnt;

  cnt_updown_scan #(.DIGITS(ND), .RADIX(16), .TICK_DIV(TDIV), .DB_DIV(2), .SCAN_DIV(SDIV)) u_hex (
    .clk100khz(clk100khz), .rst(rst), .en(en), .din(din), .op(op), .ld(ld), .ld_val(ld_val),
    .cnt_val(cnt_o[0]), .wrap(wrap_o[0]), .at_zero(at_zero_o[0]), .scan(scan_o[0]), .dout(dout_o[0]));

  cnt_updown_scan #(.DIGITS(ND), .RADIX(10), .TICK_DIV(TDIV), .DB_DIV(2), .SCAN_DIV(SDIV)) u_dec (
    .clk100khz(clk100khz), .rst(rst), .en(en), .din(din), .op(op), .ld(ld), .ld_val(ld_val),
    .cnt_val(cnt_o[1]), .wrap(wrap_o[1]), .at_zero(at_zero_o[1]), .scan(scan_o[1]), .dout(dout_o[1]));

  initial clk100khz = 1'b0;
  always #5 clk100khz = ~clk100khz;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pw(int r, int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * r;
    return p;
  endfunction

  function automatic logic [7:0] to_nib(int v, int r);
    logic [7:0] n;
    n = '0;
    for (int k = 0; k < ND; k++) n[4*k +: 4] = 4'((v / pw(r, k)) % r);
    return n;
  endfunction

  function automatic int load_val(logic [7:0] lv, int r);
    int v;
    int d;
    v = 0;
    for (int k = 0; k < ND; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > r - 1) d = r - 1;
      v = v + d * pw(r, k);
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_glyph(int v, int r, int k);
    int hi;
    hi = v / pw(r, k);
`ifdef CNT_UPDOWN_SCAN_BLANK_EN
    if (k > 0 && hi == 0) return 8'h00;
`endif
    return GLYPH[hi % r];
  endfunction

  task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, j, obs, want);
    end
  endtask

  // One clock: advance the model on the edge, then compare both instances
  task automatic cyc();
    logic [5:0] e_scan;
    logic [7:0] e_dout [2];
    bit         e_wrap [2];
    bit         stp;
    @(posedge clk100khz);
    m_step = 1'b0;
    if (rst) begin
      m_v[0] = 0; m_v[1] = 0;
      m_tph = 0; m_sph = 0; m_idx = 0;
      e_scan = 6'b000001;
      for (int j = 0; j < 2; j++) begin e_dout[j] = 8'h3F; e_wrap[j] = 1'b0; end
    end else begin
      e_scan = 6'(1) << m_idx;
      for (int j = 0; j < 2; j++) e_dout[j] = exp_glyph(m_v[j], radix[j], m_idx);
      if (m_sph == SDIV - 1) m_idx = (m_idx + 1) % ND;
      m_sph = (m_sph + 1) % SDIV;
      stp = en ? 1'b0 : (m_tph == TDIV - 1);
      m_tph = (m_tph + 1) % TDIV;
      m_step = stp && !ld;
      for (int j = 0; j < 2; j++) begin
        e_wrap[j] = 1'b0;
        if (ld) begin
          m_v[j] = load_val(ld_val, radix[j]);
        end else if (stp) begin
          if (!op) begin
            if (m_v[j] == pw(radix[j], ND) - 1) begin m_v[j] = 0; e_wrap[j] = 1'b1; end
            else m_v[j] = m_v[j] + 1;
          end else if (m_v[j] > 0) begin
            m_v[j] = m_v[j] - 1;
          end
        end
      end
    end
    #1;
    if (wrap_o[0] === 1'b1) w_cnt++;
    for (int j = 0; j < 2; j++) begin
      chk("scan", j, 32'(scan_o[j]), 32'(e_scan));
      if (chk_cnt) begin
        chk("cnt_val", j, 32'(cnt_o[j]), 32'(to_nib(m_v[j], radix[j])));
        chk("wrap", j, 32'(wrap_o[j]), 32'(e_wrap[j]));
        chk("at_zero", j, 32'(at_zero_o[j]), 32'(m_v[j] == 0));
        chk("dout", j, 32'(dout_o[j]), 32'(e_dout[j]));
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_steps(input int n);
    int got, k;
    got = 0;
    k = 0;
    while (got < n && k < 100) begin
      cyc();
      if (m_step) got++;
      k++;
    end
    chk("step_budget", 0, 32'(got), 32'(n));
  endtask

  task automatic load(input logic [7:0] v);
    ld = 1'b1;
    ld_val = v;
    cyc();
    ld = 1'b0;
  endtask

  initial begin
    int k;
    int run;
    rst = 1'b1; en = 1'b0; din = 1'b1; op = 1'b0; ld = 1'b0; ld_val = '0;
    chk_cnt = 1'b1;
    w_cnt = 0;
    m_v[0] = 0; m_v[1] = 0; m_tph = 0; m_sph = 0; m_idx = 0;
    cyc();
    chk("rst_scan", 0, 32'(scan_o[0]), 32'h01);
    chk("rst_dout", 0, 32'(dout_o[0]), 32'h3F);
    chk("rst_at_zero", 0, 32'(at_zero_o[0]), 32'h1);
    rst = 1'b0;

    // Up-wrap FE -> FF -> 00 with a single wrap pulse
    op = 1'b0;
    load(8'hFE);
    w_cnt = 0;
    run_steps(1);
    chk("upwrap_ff", 0, 32'(cnt_o[0]), 32'hFF);
    run_steps(1);
    chk("upwrap_00", 0, 32'(cnt_o[0]), 32'h00);
    chk("upwrap_zero", 0, 32'(at_zero_o[0]), 32'h1);
    chk("upwrap_pulse", 0, 32'(wrap_o[0]), 32'h1);
    cyc();
    chk("upwrap_drop", 0, 32'(wrap_o[0]), 32'h0);
    chk("upwrap_count", 0, 32'(w_cnt), 32'd1);

    // Down count saturates at zero
    op = 1'b1;
    load(8'h01);
    w_cnt = 0;
    run_steps(3);
    chk("down_sat", 0, 32'(cnt_o[0]), 32'h00);
    chk("down_sat", 1, 32'(cnt_o[1]), 32'h00);
    chk("down_nowrap", 0, 32'(w_cnt), 32'd0);

    // Decimal carry and load clamp
    op = 1'b0;
    load(8'h09);
    run_steps(1);
    chk("dec_carry", 1, 32'(cnt_o[1]), 32'h10);
    chk("hex_09p1", 0, 32'(cnt_o[0]), 32'h0A);
    load(8'h0C);
    chk("dec_clamp", 1, 32'(cnt_o[1]), 32'h09);
    chk("hex_noclamp", 0, 32'(cnt_o[0]), 32'h0C);

    // Debounce: one-sample glitch ignored, sustained press counts exactly once
    load(8'h05);
    en = 1'b1;
    cycles(4);
    chk_cnt = 1'b0;
    din = 1'b0; cycles(2);
    din = 1'b1; cycles(10);
    chk("db_glitch", 0, 32'(cnt_o[0]), 32'h05);
    din = 1'b0; cycles(6);
    cycles(20);
    chk("db_press", 0, 32'(cnt_o[0]), 32'h06);
    chk("db_press", 1, 32'(cnt_o[1]), 32'h06);
    din = 1'b1; cycles(12);
    chk("db_release", 0, 32'(cnt_o[0]), 32'h06);
    m_v[0] = 6; m_v[1] = 6;
    chk_cnt = 1'b1;
    cycles(2);

    // Scan dwell and glyphs with a held count of 05
    load(8'h05);
    k = 0;
    while (scan_o[0] !== 6'b000001 && k < 20) begin cyc(); k++; end
    while (scan_o[0] !== 6'b000010 && k < 20) begin cyc(); k++; end
    chk("scan_reach", 0, 32'(scan_o[0]), 32'h02);
    run = 0;
    while (scan_o[0] === 6'b000010 && run < 10) begin
`ifdef CNT_UPDOWN_SCAN_BLANK_EN
      chk("dout_d1", 0, 32'(dout_o[0]), 32'h00);
`else
      chk("dout_d1", 0, 32'(dout_o[0]), 32'h3F);
`endif
      cyc(); run++;
    end
    chk("dwell_d1", 0, 32'(run), 32'd3);
    run = 0;
    while (scan_o[0] === 6'b000001 && run < 10) begin
      chk("dout_d0", 0, 32'(dout_o[0]), 32'h6D);
      cyc(); run++;
    end
    chk("dwell_d0", 0, 32'(run), 32'd3);

    // Load wins over a coincident tick
    en = 1'b0;
    k = 0;
    while (m_tph != TDIV - 1 && k < 10) begin cyc(); k++; end
    load(8'h3A);
    chk("ld_over_tick", 0, 32'(cnt_o[0]), 32'h3A);
    chk("ld_over_tick", 1, 32'(cnt_o[1]), 32'h39);

    // Reset in the middle of a digit dwell
    k = 0;
    while (!(m_idx == 1 && m_sph == 1) && k < 20) begin cyc(); k++; end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_scan", 0, 32'(scan_o[0]), 32'h01);
    chk("rst_mid_dout", 0, 32'(dout_o[0]), 32'h3F);
    chk("rst_mid_cnt", 0, 32'(cnt_o[0]), 32'h00);
    chk("rst_mid_cnt", 1, 32'(cnt_o[1]), 32'h00);

    // Random op flips, loads and occasional resets against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) op = ~op;
      ld = ($urandom_range(0, 9) == 0);
      ld_val = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; ld = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
